// File: rtl/axi_rdata_aligner.sv
// Realigns AXI read beats by the byte offset of the burst start address,
// popped once per burst from a low-address FIFO, so that word 0 starts at that byte.
module axi_rdata_aligner #(
    parameter int DATA_WIDTH = 128,
    parameter int OFS_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic [OFS_WIDTH-1:0]  fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rvalid,
    input  logic                  s_rlast,
    output logic                  s_rready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [15:0]           bursts_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        FIRST = 3'd3,
        BURST = 3'd4,
        FLUSH = 3'd5
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [OFS_WIDTH-1:0]    ofs_reg;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic [DATA_WIDTH-1:0]   m_data_reg;
    logic                    m_valid_reg;
    logic                    m_last_reg;
    logic [15:0]             bursts_done_reg;

    logic                    out_free;
    logic                    beat_acc;
    logic                    beat_load;
    logic                    flush_load;
    logic                    rd_en_next;
    logic                    rready_next;
    logic [OFS_WIDTH+2:0]    shift_bits;
    logic [DATA_WIDTH-1:0]   aligned_beat;
    logic [DATA_WIDTH-1:0]   aligned_flush;

    // The output slot can take a new word when empty or being drained this cycle.
    assign out_free   = !m_valid_reg || m_ready;
    assign shift_bits = {ofs_reg, 3'b000};

    assign aligned_beat  = DATA_WIDTH'({s_rdata, hold_reg} >> shift_bits);
    assign aligned_flush = hold_reg >> shift_bits;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_en_next  = 1'b0;
        rready_next = 1'b0;
        flush_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_next = 1'b1;
                    state_next = POP;
                end
            end
            POP:   state_next = LOAD;
            LOAD:  state_next = FIRST;
            FIRST: begin
                rready_next = 1'b1;
                if (s_rvalid) begin
                    state_next = s_rlast ? FLUSH : BURST;
                end
            end
            BURST: begin
                rready_next = out_free;
                if (s_rvalid && out_free && s_rlast) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    flush_load = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // IDLE is the reset state, so the pop request must be masked while reset is held.
    assign fifo_rd_en = rd_en_next && !tb_rst;
    assign s_rready   = rready_next;
    assign beat_acc   = s_rvalid && rready_next;
    assign beat_load  = beat_acc && (state_reg == BURST);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            ofs_reg         <= '0;
            hold_reg        <= '0;
            m_data_reg      <= '0;
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            bursts_done_reg <= '0;
        end else begin
            if (state_reg == POP) begin
                ofs_reg <= fifo_rd_data;
            end
            if (beat_acc) begin
                hold_reg <= s_rdata;
            end
            if (beat_load) begin
                m_data_reg  <= aligned_beat;
                m_valid_reg <= 1'b1;
                m_last_reg  <= 1'b0;
            end else if (flush_load) begin
                m_data_reg      <= aligned_flush;
                m_valid_reg     <= 1'b1;
                m_last_reg      <= 1'b1;
                bursts_done_reg <= bursts_done_reg + 16'd1;
            end else if (m_ready) begin
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end
        end
    end

    assign m_data      = m_data_reg;
    assign m_valid     = m_valid_reg;
    assign m_last      = m_last_reg;
    assign bursts_done = bursts_done_reg;

endmodule

// File: tb/tb_axi_rdata_aligner.sv
// Directed and randomized bursts through axi_rdata_aligner, compared against a
// byte-stream model: output word k = bytes [ofs+16k .. ofs+16k+15] of the burst, zero past the end.
module tb_axi_rdata_aligner;

    localparam int DW = 128;

    logic           clk = 1'b0;
    logic           tb_rst = 1'b1;
    logic [3:0]     fifo_rd_data = '0;
    logic           fifo_empty = 1'b1;
    logic           fifo_rd_en;
    logic [DW-1:0]  s_rdata = '0;
    logic           s_rvalid = 1'b0;
    logic           s_rlast = 1'b0;
    logic           s_rready;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b1;
    logic [15:0]    bursts_done;

    axi_rdata_aligner #(.DATA_WIDTH(DW), .OFS_WIDTH(4)) dut (
        .clk(clk), .tb_rst(tb_rst),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .bursts_done(bursts_done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] beats[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [3:0]    ofs_q[$];
    int            beat_i = 0;
    int            rmode = 0;
    int            stall_left = 0;
    bit            stall_done = 0;
    bit            holding = 0;
    bit            acc = 0;
    bit            popd = 0;
    int            rd_pulses = 0;
    int            exp_bursts = 0;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        if (beat_i < beats.size()) begin
            if (!holding) s_rvalid = (rmode != 1) || ($urandom_range(0, 2) != 0);
            s_rdata = beats[beat_i];
            s_rlast = (beat_i == beats.size() - 1);
        end else begin
            s_rvalid = 1'b0;
            s_rdata  = '0;
            s_rlast  = 1'b0;
        end
        if (rmode == 1) begin
            m_ready = ($urandom_range(0, 3) != 0);
        end else if (rmode == 2) begin
            if (!stall_done && got_d.size() == 2) begin
                stall_left = 5;
                stall_done = 1;
            end
            m_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end else begin
            m_ready = 1'b1;
        end
    endtask

    // One clock: sample at the falling edge, update the FIFO/beat models after the rising edge.
    task automatic step();
        @(negedge clk);
        acc  = s_rvalid && s_rready;
        popd = fifo_rd_en;
        if (popd) rd_pulses++;
        if (m_valid && !m_ready) begin
            check("stall_rready", DW'(s_rready), DW'(0));
            if (prev_hold) begin
                check("stall_data", m_data, prev_data);
                check("stall_last", DW'(m_last), DW'(prev_last));
            end
            prev_hold = 1;
            prev_data = m_data;
            prev_last = m_last;
        end else begin
            prev_hold = 0;
        end
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end
        @(posedge clk);
        #1;
        if (acc) beat_i++;
        holding = s_rvalid && !acc;
        if (popd && ofs_q.size() > 0) fifo_rd_data = ofs_q.pop_front();
        fifo_empty = (ofs_q.size() == 0);
        drive_inputs();
    endtask

    task automatic build_expected(input int ofs);
        int n;
        n = beats.size();
        exp_d.delete();
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] w;
            w = '0;
            for (int j = 0; j < 16; j++) begin
                int idx;
                logic [DW-1:0] bv;
                idx = ofs + 16 * k + j;
                if (idx < 16 * n) begin
                    bv = beats[idx / 16];
                    w[8*j +: 8] = bv[8*(idx % 16) +: 8];
                end
            end
            exp_d.push_back(w);
        end
    endtask

    task automatic run_burst(input int ofs, input int mode, input string tag);
        int n;
        int cyc;
        int pulses0;
        logic [3:0] o4;
        n = beats.size();
        build_expected(ofs);
        got_d.delete();
        got_l.delete();
        beat_i = 0;
        holding = s_rvalid;
        stall_done = 0;
        stall_left = 0;
        rmode = mode;
        o4 = ofs[3:0];
        ofs_q.push_back(o4);
        fifo_empty = 1'b0;
        pulses0 = rd_pulses;
        drive_inputs();
        cyc = 0;
        while (!(got_l.size() > 0 && got_l[got_l.size()-1]) && cyc < 500) begin
            step();
            cyc++;
        end
        check({tag, "_timeout"}, DW'(cyc >= 500), DW'(0));
        check({tag, "_nwords"}, DW'(got_d.size()), DW'(n));
        for (int k = 0; k < n && k < got_d.size(); k++) begin
            check($sformatf("%s_word%0d", tag, k), got_d[k], exp_d[k]);
            check($sformatf("%s_last%0d", tag, k), DW'(got_l[k]), DW'(k == n - 1));
        end
        exp_bursts++;
        check({tag, "_bursts_done"}, DW'(bursts_done), DW'(exp_bursts));
        check({tag, "_pops"}, DW'(rd_pulses - pulses0), DW'(1));
        $display("burst %s ofs=%0d beats=%0d words=%0d bursts_done=%0d", tag, ofs, n, got_d.size(), bursts_done);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_rd_en", DW'(fifo_rd_en), DW'(0));
        check("rst_rready", DW'(s_rready), DW'(0));
        check("rst_valid_last", DW'({m_valid, m_last}), DW'(0));
        check("rst_data", m_data, DW'(0));
        check("rst_bursts", DW'(bursts_done), DW'(0));
        @(posedge clk);
        #1;
        tb_rst = 1'b0;

        // Offset 0, four beats, always ready
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        run_burst(0, 0, "ofs0_4beat");

        // Offset 3, two beats with byte i = i
        beats.delete();
        for (int b = 0; b < 2; b++) begin
            logic [DW-1:0] w;
            for (int j = 0; j < 16; j++) w[8*j +: 8] = 8'(16 * b + j);
            beats.push_back(w);
        end
        run_burst(3, 0, "ofs3_ramp");
        if (got_d.size() == 2) begin
            check("ofs3_w0_byte0", DW'(got_d[0][7:0]), DW'(8'h03));
            check("ofs3_w1_top", DW'(got_d[1][127:104]), DW'(0));
        end

        // Single beat, offset 15
        beats.delete();
        beats.push_back({$urandom, $urandom, $urandom, $urandom});
        run_burst(15, 0, "ofs15_single");
        if (got_d.size() == 1) begin
            check("ofs15_byte0", DW'(got_d[0][7:0]), DW'(beats[0][127:120]));
            check("ofs15_upper", DW'(got_d[0][127:8]), DW'(0));
        end

        // Five-cycle downstream stall mid-burst
        beats.delete();
        for (int i = 0; i < 6; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        run_burst($urandom_range(0, 15), 2, "stall5");

        // Beats presented while the FIFO is empty must wait
        beats.delete();
        for (int i = 0; i < 3; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        beat_i = 0;
        holding = 0;
        rmode = 0;
        got_d.delete();
        got_l.delete();
        drive_inputs();
        for (int c = 0; c < 8; c++) begin
            step();
            check("empty_rready", DW'(s_rready), DW'(0));
            check("empty_mvalid", DW'(m_valid), DW'(0));
        end
        run_burst(2, 0, "ofs2_after_wait");

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            beats.delete();
            for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
            run_burst($urandom_range(0, 15), 1, $sformatf("rand%0d", r));
        end

        // Reset mid-burst after two accepted beats
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        beat_i = 0;
        holding = 0;
        rmode = 0;
        ofs_q.push_back(4'd7);
        fifo_empty = 1'b0;
        drive_inputs();
        for (int c = 0; c < 50 && beat_i < 2; c++) step();
        check("midrst_reached", DW'(beat_i), DW'(2));
        tb_rst = 1'b1;
        beats.delete();
        drive_inputs();
        #2;
        check("midrst_valid_last", DW'({m_valid, m_last}), DW'(0));
        check("midrst_data", m_data, DW'(0));
        check("midrst_ready_pop", DW'({s_rready, fifo_rd_en}), DW'(0));
        check("midrst_bursts", DW'(bursts_done), DW'(0));
        $display("reset pulse mid-burst bursts_done=%0d m_valid=%0b", bursts_done, m_valid);
        @(posedge clk);
        #3;
        tb_rst = 1'b0;
        exp_bursts = 0;
        prev_hold = 0;
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
        run_burst(5, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rdata_aligner.md
AXI_RDATA_ALIGNER -- requirements
Module: axi_rdata_aligner

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SHALL set the R-channel and output data width in bits.
REQ-002 Parameter OFS_WIDTH, default 4, SHALL equal log2(DATA_WIDTH/8) and SHALL be the byte-offset width held in the low-address FIFO.
REQ-003 Clock and reset: clk, reset tb_rst, asynchronous, active-high; clock clk.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock
- tb_rst  in  1  async active-high reset
- fifo_rd_data  in  OFS_WIDTH  araddr low bits from the low-address FIFO (non-registered FIFO output, valid the cycle after fifo_rd_en)
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop, one cycle per burst
- s_rdata  in  DATA_WIDTH  AXI read data
- s_rvalid  in  1  beat valid
- s_rlast  in  1  last beat of burst
- s_rready  out  1  beat accept
- m_data  out  DATA_WIDTH  byte-aligned data
- m_valid  out  1  output valid
- m_last  out  1  last aligned word of burst
- m_ready  in  1  downstream accept
- bursts_done  out  16  completed-burst counter, wraps 0xFFFF->0

Function
REQ-005 FSM states SHALL be IDLE, POP, LOAD, FIRST, BURST, FLUSH.
REQ-006 IDLE: when fifo_empty=0, fifo_rd_en SHALL be 1 for exactly one cycle and the FSM SHALL go to POP; otherwise it SHALL stay in IDLE.
REQ-007 POP: fifo_rd_en SHALL be 0, and fifo_rd_data SHALL be captured into ofs_reg at the end of the cycle; next state LOAD.
REQ-008 LOAD: one idle cycle, after which the next state SHALL be FIRST.
REQ-009 s_rready SHALL be 1 only in FIRST, and in BURST when (m_valid=0 or m_ready=1); it SHALL be 0 in IDLE, POP, LOAD and FLUSH.
REQ-010 FIRST: an accepted beat SHALL be stored in hold_reg with no output. If s_rlast=1 the next state SHALL be FLUSH, otherwise BURST.
REQ-011 BURST: each accepted beat k SHALL load m_data = ({s_rdata, hold_reg} >> (8*ofs_reg))[DATA_WIDTH-1:0], set m_valid=1 and m_last=0, and store s_rdata into hold_reg. On an s_rlast beat the next state SHALL be FLUSH.
REQ-012 FLUSH: when (m_valid=0 or m_ready=1), the block SHALL load m_data = ({zeros, hold_reg} >> (8*ofs_reg)) with m_valid=1 and m_last=1, increment bursts_done, and go to IDLE.
REQ-013 An N-beat burst SHALL produce exactly N output words. Latency from an accepted beat to its aligned word SHALL be one accepted beat; latency from the rlast beat to the m_last word SHALL be 1 cycle when m_ready=1.
REQ-014 With ofs_reg=0, output word k SHALL equal input beat k exactly, and the zero fill in FLUSH SHALL not appear in m_data.
REQ-015 m_valid SHALL stay at 1 and m_data/m_last SHALL stay stable while m_ready=0. m_valid SHALL clear on m_ready=1 when no new word is loaded in the same cycle.
REQ-016 s_rvalid asserted in IDLE/POP/LOAD/FLUSH SHALL be stalled (s_rready=0) and SHALL never be dropped.
REQ-017 A new burst SHALL begin (IDLE pop) in the cycle after the FLUSH word loads, even while that m_last word is still pending on m_ready.
REQ-018 Shift SHALL be in whole bytes; bytes shifted in from above the concatenation SHALL be 0.

Reset
REQ-019 While tb_rst=1, the following SHALL hold:
- state=IDLE
- fifo_rd_en=0, s_rready=0, m_valid=0, m_last=0
- m_data=0, ofs_reg=0, hold_reg=0, bursts_done=0
REQ-020 Reset asserted mid-burst SHALL abandon the burst with no m_last and no counter increment. After release, the block SHALL restart from IDLE.

Verification
REQ-021 Offset 0, 4-beat burst (beats A,B,C,D), m_ready=1 -> m_data A,B,C,D; m_last only on D; bursts_done=1; one fifo_rd_en pulse.
REQ-022 Offset 3, 2 beats with byte i = i (0x00..0x1F) -> word0 bytes 0x03..0x12; word1 bytes 0x13..0x1F followed by 3 zero bytes; m_last on word1.
REQ-023 Single-beat burst, offset 15 -> one word with byte0 = beat byte15 and the upper 15 bytes zero; m_last=1.
REQ-024 m_ready held 0 for 5 cycles mid-burst -> s_rready=0 during the stall; m_data stable; no beat lost or duplicated; order preserved.
REQ-025 s_rvalid asserted while fifo_empty=1 -> s_rready stays 0 and no output appears. Pushing offset 2 into the FIFO -> pop, then normal alignment.
REQ-026 tb_rst pulsed after beat 2 of 4 -> all outputs 0. The next burst after reset aligns correctly, and bursts_done counts from 0.
